// File: rtl/mc_ctrl_pkg.sv
// Shared types and constants for the multicycle control unit.
package mc_ctrl_pkg;

    localparam int unsigned STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        EXEC_R  = 4'd2,
        EXEC_I  = 4'd3,
        ALU_WB  = 4'd4,
        MEM_ADR = 4'd5,
        MEM_RD  = 4'd6,
        MEM_WR  = 4'd7,
        MEM_WB  = 4'd8,
        BRANCH  = 4'd9
    } state_t;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [1:0] SRCB_REG  = 2'd0;
    localparam logic [1:0] SRCB_IMM  = 2'd1;
    localparam logic [1:0] SRCB_FOUR = 2'd2;

    localparam logic [1:0] RES_ALUOUT = 2'd0;
    localparam logic [1:0] RES_DATA   = 2'd1;
    localparam logic [1:0] RES_ALU    = 2'd2;

    typedef struct packed {
        logic       ir_w;
        logic       pc_w;
        logic       adr_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        logic       reg_w;
        logic       mem_w;
        logic       branch;
        logic       alu_op;
        logic       instr_done;
    } ctrl_t;

endpackage

// File: rtl/mc_out_deco.sv
// Moore control word for each state; ready only matters where memory is accessed.
module mc_out_deco
    import mc_ctrl_pkg::*;
(
    input  state_t state,
    input  logic   ready,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            FETCH: begin
                ctrl.alu_src_a  = 1'b1;
                ctrl.alu_src_b  = SRCB_FOUR;
                ctrl.result_src = RES_ALU;
                ctrl.ir_w       = ready;
                ctrl.pc_w       = ready;
            end
            DECODE: begin
                ctrl.alu_src_a  = 1'b1;
                ctrl.alu_src_b  = SRCB_FOUR;
                ctrl.result_src = RES_ALU;
            end
            EXEC_R: begin
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_op    = 1'b1;
            end
            EXEC_I: begin
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = 1'b1;
            end
            ALU_WB: begin
                ctrl.result_src = RES_ALUOUT;
                ctrl.reg_w      = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            MEM_ADR: begin
                ctrl.alu_src_b = SRCB_IMM;
            end
            MEM_RD: begin
                ctrl.adr_src = 1'b1;
            end
            MEM_WR: begin
                ctrl.adr_src    = 1'b1;
                ctrl.mem_w      = 1'b1;
                ctrl.instr_done = ready;
            end
            MEM_WB: begin
                ctrl.result_src = RES_DATA;
                ctrl.reg_w      = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            BRANCH: begin
                ctrl.alu_src_b  = SRCB_IMM;
                ctrl.result_src = RES_ALU;
                ctrl.branch     = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle control sequencer: fetch/decode/execute/memory/write-back with memory wait states.
module mc_control_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned FUNCT_W   = 6,
    parameter int unsigned I_BIT     = 5,
    parameter int unsigned L_BIT     = 0,
    parameter int unsigned USE_READY = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         op,
    input  logic [FUNCT_W-1:0] funct,
    input  logic               mem_ready,
    output logic               ir_w,
    output logic               pc_w,
    output logic               adr_src,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         result_src,
    output logic [1:0]         imm_src,
    output logic [1:0]         reg_src,
    output logic               reg_w,
    output logic               mem_w,
    output logic               branch,
    output logic               alu_op,
    output logic               illegal,
    output logic               instr_done,
    output logic [3:0]         state_o
);

    state_t state_q;
    state_t state_d;
    ctrl_t  ctrl;
    logic   ready;
    logic   dec_illegal;
    logic   unused_funct;

    assign ready        = (USE_READY != 0) ? mem_ready : 1'b1;
    assign dec_illegal  = (state_q == DECODE) && (op == 2'b11);
    assign unused_funct = ^funct;

    mc_out_deco u_out_deco (
        .state (state_q),
        .ready (ready),
        .ctrl  (ctrl)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:   if (ready) state_d = DECODE;
            DECODE: begin
                case (op)
                    OP_DP:   state_d = funct[I_BIT] ? EXEC_I : EXEC_R;
                    OP_MEM:  state_d = MEM_ADR;
                    OP_BR:   state_d = BRANCH;
                    default: state_d = FETCH;
                endcase
            end
            EXEC_R:  state_d = ALU_WB;
            EXEC_I:  state_d = ALU_WB;
            ALU_WB:  state_d = FETCH;
            MEM_ADR: state_d = funct[L_BIT] ? MEM_RD : MEM_WR;
            MEM_RD:  if (ready) state_d = MEM_WB;
            MEM_WR:  if (ready) state_d = FETCH;
            MEM_WB:  state_d = FETCH;
            BRANCH:  state_d = FETCH;
            default: state_d = FETCH;
        endcase
    end

    // Write enables and pulses are masked by rst_n so FETCH's ready-driven ir_w/pc_w stay low in reset.
    always_comb begin
        ir_w       = ctrl.ir_w & rst_n;
        pc_w       = ctrl.pc_w & rst_n;
        adr_src    = ctrl.adr_src;
        alu_src_a  = ctrl.alu_src_a;
        alu_src_b  = ctrl.alu_src_b;
        result_src = ctrl.result_src;
        reg_w      = ctrl.reg_w & rst_n;
        mem_w      = ctrl.mem_w & rst_n;
        branch     = ctrl.branch & rst_n;
        alu_op     = ctrl.alu_op;
        illegal    = dec_illegal & rst_n;
        instr_done = (ctrl.instr_done | dec_illegal) & rst_n;
        imm_src    = op;
        reg_src    = {(op == OP_MEM) && !funct[L_BIT], op == OP_BR};
        state_o    = 4'(state_q);
    end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm with a step-level behavioural model and per-cycle compare.
module tb_mc_control_fsm;
    import mc_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] op;
    logic [5:0] funct;
    logic       mem_ready;
    logic       ir_w, pc_w, adr_src, alu_src_a;
    logic [1:0] alu_src_b, result_src, imm_src, reg_src;
    logic       reg_w, mem_w, branch, alu_op, illegal, instr_done;
    logic [3:0] state_o;

    int checks   = 0;
    int failures = 0;
    int cyc_cnt  = 0;
    int done_cnt = 0;
    int ill_cnt  = 0;
    int exp_lat  = 0;

    typedef struct packed {
        logic [3:0] st;
        logic       ir_w, pc_w, adr_src, alu_src_a;
        logic [1:0] alu_src_b, result_src, imm_src, reg_src;
        logic       reg_w, mem_w, branch, alu_op, illegal, instr_done;
    } exp_t;

    exp_t exp_c;
    logic exp_valid = 1'b0;

    mc_control_fsm dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .mem_ready(mem_ready),
        .ir_w(ir_w), .pc_w(pc_w), .adr_src(adr_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .result_src(result_src), .imm_src(imm_src),
        .reg_src(reg_src), .reg_w(reg_w), .mem_w(mem_w), .branch(branch),
        .alu_op(alu_op), .illegal(illegal), .instr_done(instr_done), .state_o(state_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, req);
        end
    endtask

    // Expected outputs of one step, written straight from the state/output table.
    function automatic exp_t model(input state_t s, input logic rdy, input logic [1:0] o,
                                   input logic [5:0] f);
        exp_t e = '0;
        e.st      = 4'(s);
        e.imm_src = o;
        e.reg_src = {(o == 2'b01) && !f[0], o == 2'b10};
        case (s)
            FETCH:   begin e.alu_src_a = 1; e.alu_src_b = 2; e.result_src = 2;
                           e.ir_w = rdy; e.pc_w = rdy; end
            DECODE:  begin e.alu_src_a = 1; e.alu_src_b = 2; e.result_src = 2;
                           e.illegal = (o == 2'b11); e.instr_done = (o == 2'b11); end
            EXEC_R:  begin e.alu_src_b = 0; e.alu_op = 1; end
            EXEC_I:  begin e.alu_src_b = 1; e.alu_op = 1; end
            ALU_WB:  begin e.result_src = 0; e.reg_w = 1; e.instr_done = 1; end
            MEM_ADR: begin e.alu_src_b = 1; end
            MEM_RD:  begin e.adr_src = 1; end
            MEM_WR:  begin e.adr_src = 1; e.mem_w = 1; e.instr_done = rdy; end
            MEM_WB:  begin e.result_src = 1; e.reg_w = 1; e.instr_done = 1; end
            BRANCH:  begin e.alu_src_b = 1; e.result_src = 2; e.branch = 1; e.instr_done = 1; end
            default: e = '0;
        endcase
        return e;
    endfunction

    always @(negedge clk) begin
        if (exp_valid) begin
            chk("state_o",    state_o,           exp_c.st);
            chk("ir_w",       4'(ir_w),          4'(exp_c.ir_w));
            chk("pc_w",       4'(pc_w),          4'(exp_c.pc_w));
            chk("adr_src",    4'(adr_src),       4'(exp_c.adr_src));
            chk("alu_src_a",  4'(alu_src_a),     4'(exp_c.alu_src_a));
            chk("alu_src_b",  4'(alu_src_b),     4'(exp_c.alu_src_b));
            chk("result_src", 4'(result_src),    4'(exp_c.result_src));
            chk("imm_src",    4'(imm_src),       4'(exp_c.imm_src));
            chk("reg_src",    4'(reg_src),       4'(exp_c.reg_src));
            chk("reg_w",      4'(reg_w),         4'(exp_c.reg_w));
            chk("mem_w",      4'(mem_w),         4'(exp_c.mem_w));
            chk("branch",     4'(branch),        4'(exp_c.branch));
            chk("alu_op",     4'(alu_op),        4'(exp_c.alu_op));
            chk("illegal",    4'(illegal),       4'(exp_c.illegal));
            chk("instr_done", 4'(instr_done),    4'(exp_c.instr_done));
            cyc_cnt++;
            if (instr_done === 1'b1) begin
                chk("latency", 4'(cyc_cnt), 4'(exp_lat));
                cyc_cnt = 0;
                done_cnt++;
            end
            if (illegal === 1'b1) ill_cnt++;
        end
    end

    task automatic step(input state_t s, input logic rdy);
        mem_ready = rdy;
        exp_c     = model(s, rdy, op, funct);
        exp_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    // One instruction: fw fetch waits, mw memory waits, lat = hand-computed total cycles.
    task automatic run_instr(input logic [1:0] o, input logic [5:0] f, input int fw,
                             input int mw, input int lat);
        op = o; funct = f;
        cyc_cnt = 0; done_cnt = 0; ill_cnt = 0; exp_lat = lat;
        for (int i = 0; i < fw; i++) step(FETCH, 1'b0);
        step(FETCH, 1'b1);
        step(DECODE, rnd());
        case (o)
            2'b00: begin
                step(f[5] ? EXEC_I : EXEC_R, rnd());
                step(ALU_WB, rnd());
            end
            2'b01: begin
                step(MEM_ADR, rnd());
                if (f[0]) begin
                    for (int i = 0; i < mw; i++) step(MEM_RD, 1'b0);
                    step(MEM_RD, 1'b1);
                    step(MEM_WB, rnd());
                end else begin
                    for (int i = 0; i < mw; i++) step(MEM_WR, 1'b0);
                    step(MEM_WR, 1'b1);
                end
            end
            2'b10: step(BRANCH, rnd());
            default: ;
        endcase
        chk("done_count", 4'(done_cnt), 4'd1);
        chk("illegal_count", 4'(ill_cnt), (o == 2'b11) ? 4'd1 : 4'd0);
    endtask

    initial begin
        rst_n = 1'b0; mem_ready = 1'b1; op = 2'b00; funct = 6'b0;
        repeat (3) begin
            @(negedge clk);
            chk("rst_state", state_o, 4'd0);
            chk("rst_ir_w", 4'(ir_w), 4'd0);
            chk("rst_pc_w", 4'(pc_w), 4'd0);
            chk("rst_alu_src_b", 4'(alu_src_b), 4'd2);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;

        run_instr(2'b00, 6'b100000, 0, 0, 4);
        run_instr(2'b00, 6'b000011, 1, 0, 5);
        run_instr(2'b01, 6'b000001, 0, 2, 7);
        run_instr(2'b01, 6'b000000, 0, 3, 7);
        run_instr(2'b01, 6'b100000, 0, 0, 4);
        run_instr(2'b10, 6'b000000, 0, 0, 3);
        run_instr(2'b10, 6'b010101, 2, 0, 5);
        run_instr(2'b11, 6'b000000, 0, 0, 2);
        run_instr(2'b00, 6'b000000, 0, 0, 4);
        run_instr(2'b01, 6'b000001, 1, 0, 6);

        // Abandon a store mid-wait with an asynchronous reset.
        op = 2'b01; funct = 6'b000000; cyc_cnt = 0;
        step(FETCH, 1'b1);
        step(DECODE, 1'b1);
        step(MEM_ADR, 1'b1);
        mem_ready = 1'b0;
        exp_c = model(MEM_WR, 1'b0, op, funct);
        @(negedge clk); #1;
        exp_valid = 1'b0;
        chk("abort_mem_w_before", 4'(mem_w), 4'd1);
        mem_ready = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("abort_mem_w", 4'(mem_w), 4'd0);
        chk("abort_state", state_o, 4'd0);
        chk("abort_ir_w", 4'(ir_w), 4'd0);
        chk("abort_done", 4'(instr_done), 4'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        run_instr(2'b00, 6'b100000, 0, 0, 4);

        exp_valid = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
